// File: rtl/anton_neopixel_decoder.sv
// anton_neopixel_decoder: receive side of a WS2812-style single-wire stream.
// Samples the line through a 2-FF synchronizer, decodes bits by high-pulse width,
// assembles MSB-first bytes with a buffer address and reports frames on each sync.
// Optional build macro ANTON_NEOPIXEL_DECODER_FWD_EN adds neoDataFwd, which
// replays the line from the fourth byte of each frame for chaining.
//
// state     | meaning
// WAIT_SYNC | data ignored until a full low period (after reset or stuck error)
// IDLE      | synced, between frames, waiting for the first rise
// LOW       | inside a frame, line low between bits
// HIGH      | inside a frame, measuring a high pulse
`timescale 1ns/1ps

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 7
`endif
`ifndef RESET_DELAY_DEFAULT
`define RESET_DELAY_DEFAULT 20
`endif

module anton_neopixel_decoder #(
    parameter int BUFFER_END  = `BUFFER_END_DEFAULT,
    parameter int RESET_DELAY = `RESET_DELAY_DEFAULT,
    parameter int ONE_MIN     = 4,
    parameter int MAX_HIGH    = 7
) (
    input  logic                                   clk6_4mhz,
    input  logic                                   reset,
    input  logic                                   neoDataIn,
    output logic [7:0]                             dataByte,
    output logic                                   dataValid,
    output logic [$clog2(BUFFER_END + 1) - 1:0]    byteAddr,
    output logic                                   frameDone,
    output logic [$clog2(BUFFER_END + 1):0]        frameLen,
    output logic                                   errGlitch,
    output logic                                   errStuck,
    output logic                                   errOverflow,
    output logic                                   synced
`ifdef ANTON_NEOPIXEL_DECODER_FWD_EN
    ,
    output logic                                   neoDataFwd
`endif
);

    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
    localparam int LOW_W       = $clog2(RESET_DELAY + 1);
    localparam logic [LOW_W-1:0]     LOW_SYNC   = LOW_W'(RESET_DELAY);
    localparam logic [BUFFER_BITS:0] BYTE_SAT   = (BUFFER_BITS + 1)'(BUFFER_END + 1);
    localparam logic [3:0]           ONE_MIN_C  = 4'(ONE_MIN);
    localparam logic [3:0]           MAX_HIGH_C = 4'(MAX_HIGH);

    typedef enum logic [1:0] {WAIT_SYNC, IDLE, LOW, HIGH} state_t;

    logic                   sync1_q, line_q, prev_q;
    logic                   rise, fall;
    logic [3:0]             high_cnt_q;
    logic [LOW_W-1:0]       low_cnt_q;
    state_t                 state_q;
    logic [7:0]             shreg_q, shreg_d;
    logic [2:0]             bit_cnt_q;
    logic [BUFFER_BITS:0]   byte_cnt_q;
    logic [7:0]             data_byte_q;
    logic                   data_valid_q;
    logic [BUFFER_BITS-1:0] byte_addr_q;
    logic                   frame_done_q;
    logic [BUFFER_BITS:0]   frame_len_q;
    logic                   err_glitch_q, err_stuck_q, err_overflow_q;
    logic                   synced_q;
    logic                   clr_pend_q;

    assign rise    = line_q & ~prev_q;
    assign fall    = ~line_q & prev_q;
    assign shreg_d = {shreg_q[6:0], (high_cnt_q >= ONE_MIN_C)};

    // Synchronize the pin, keep an edge-detect copy and measure high/low run lengths.
    always_ff @(posedge clk6_4mhz) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            line_q     <= 1'b0;
            prev_q     <= 1'b0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
        end else begin
            sync1_q <= neoDataIn;
            line_q  <= sync1_q;
            prev_q  <= line_q;
            if (line_q) begin
                high_cnt_q <= (high_cnt_q == 4'hF) ? high_cnt_q : high_cnt_q + 4'd1;
                low_cnt_q  <= '0;
            end else begin
                high_cnt_q <= '0;
                low_cnt_q  <= (low_cnt_q == LOW_SYNC) ? low_cnt_q : low_cnt_q + LOW_W'(1);
            end
        end
    end

    // Frame FSM: bit decode, byte assembly, sync handling and sticky error flags.
    always_ff @(posedge clk6_4mhz) begin
        if (reset) begin
            state_q        <= WAIT_SYNC;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            byte_cnt_q     <= '0;
            data_byte_q    <= '0;
            data_valid_q   <= 1'b0;
            byte_addr_q    <= '0;
            frame_done_q   <= 1'b0;
            frame_len_q    <= '0;
            err_glitch_q   <= 1'b0;
            err_stuck_q    <= 1'b0;
            err_overflow_q <= 1'b0;
            synced_q       <= 1'b0;
            clr_pend_q     <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                WAIT_SYNC: begin
                    if (low_cnt_q == LOW_SYNC) begin
                        synced_q <= 1'b1;
                        state_q  <= rise ? HIGH : IDLE;
                    end
                end
                IDLE, LOW: begin
                    if (state_q == LOW && low_cnt_q == LOW_SYNC) begin
                        if (bit_cnt_q != 3'd0) err_glitch_q <= 1'b1;
                        if (bit_cnt_q != 3'd0 || byte_cnt_q != '0) begin
                            frame_done_q <= 1'b1;
                            frame_len_q  <= byte_cnt_q;
                            clr_pend_q   <= 1'b1;
                        end
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                        shreg_q    <= '0;
                        state_q    <= rise ? HIGH : IDLE;
                    end else if (rise) begin
                        // First rise after a reported frame starts a clean error window.
                        if (clr_pend_q) begin
                            err_glitch_q   <= 1'b0;
                            err_overflow_q <= 1'b0;
                            clr_pend_q     <= 1'b0;
                        end
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (high_cnt_q > MAX_HIGH_C) begin
                        // Stuck line: drop the partial frame silently and resync.
                        err_stuck_q <= 1'b1;
                        synced_q    <= 1'b0;
                        bit_cnt_q   <= '0;
                        byte_cnt_q  <= '0;
                        shreg_q     <= '0;
                        state_q     <= WAIT_SYNC;
                    end else if (fall) begin
                        shreg_q   <= shreg_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q < BYTE_SAT) begin
                                data_byte_q  <= shreg_d;
                                data_valid_q <= 1'b1;
                                byte_addr_q  <= byte_cnt_q[BUFFER_BITS-1:0];
                                byte_cnt_q   <= byte_cnt_q + (BUFFER_BITS + 1)'(1);
                            end else begin
                                err_overflow_q <= 1'b1;
                            end
                        end
                        state_q <= LOW;
                    end
                end
                default: state_q <= WAIT_SYNC;
            endcase
        end
    end

`ifdef ANTON_NEOPIXEL_DECODER_FWD_EN
    logic fwd_gate_q, fwd_q;
    logic fwd_open;

    // The gate only changes at a rise, so a forwarded pulse is never cut short.
    assign fwd_open = synced_q && (byte_cnt_q >= (BUFFER_BITS + 1)'(3));

    // Forward the synchronized line one cycle late from the fourth byte on.
    always_ff @(posedge clk6_4mhz) begin
        if (reset) begin
            fwd_gate_q <= 1'b0;
            fwd_q      <= 1'b0;
        end else begin
            if (rise) fwd_gate_q <= fwd_open;
            fwd_q <= line_q && (rise ? fwd_open : fwd_gate_q);
        end
    end

    assign neoDataFwd = fwd_q;
`endif

    assign dataByte    = data_byte_q;
    assign dataValid   = data_valid_q;
    assign byteAddr    = byte_addr_q;
    assign frameDone   = frame_done_q;
    assign frameLen    = frame_len_q;
    assign errGlitch   = err_glitch_q;
    assign errStuck    = err_stuck_q;
    assign errOverflow = err_overflow_q;
    assign synced      = synced_q;

endmodule
